// File: rtl/dbf_line_sequencer_pkg.sv
// Shared types for the DBF scanline sequencer: one-hot FSM encoding and bus defaults.
package dbf_line_sequencer_pkg;

  localparam int unsigned AddrWdDefault = 10;

  typedef enum logic [5:0] {
    StIdle   = 6'b000001,
    StWr     = 6'b000010,
    StTxWait = 6'b000100,
    StSettle = 6'b001000,
    StAcq    = 6'b010000,
    StDone   = 6'b100000
  } state_e;

endpackage

// File: rtl/dbf_line_sequencer_tc_counter.sv
// Clearable up-counter with terminal-count flag; holds at Limit instead of wrapping.
module dbf_line_sequencer_tc_counter #(
  parameter int unsigned Width = 8,
  parameter int unsigned Limit = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  assign tc_o  = (cnt_q == Width'(Limit));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dbf_line_sequencer.sv
// Per-scanline controller: serialises host LUT writes between lines and steps the shared
// LUT read address after each TX burst.
module dbf_line_sequencer
  import dbf_line_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WD    = AddrWdDefault,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned TX_TIMEOUT = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               line_trig_i,
  input  logic               tx_en_i,
  input  logic               host_wr_req_i,
  input  logic [ADDR_WD-1:0] host_wr_addr_i,
  output logic               host_wr_ack_o,
  output logic [ADDR_WD-1:0] dbf_lut_addr_o,
  output logic               dbf_lut_we_o,
  output logic               start_o,
  output logic               line_busy_o,
  output logic               line_done_o,
  output logic               line_err_o
);

  localparam int unsigned TmoWd       = $clog2(TX_TIMEOUT);
  localparam int unsigned SettleLimit = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam bit          NoSettle    = (SETTLE == 0);

  state_e             state_d, state_q;
  logic               seen_hi_d, seen_hi_q;
  logic [ADDR_WD-1:0] lut_addr_d, lut_addr_q;
  logic               lut_we_d, lut_we_q;
  logic               ack_d, ack_q;
  logic               start_d, start_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic               err_d, err_q;

  logic               tmo_tc, settle_tc, samp_tc;
  logic [TmoWd-1:0]   tmo_cnt;
  logic [7:0]         settle_cnt;
  logic [ADDR_WD-1:0] samp_cnt;
  logic               unused_cnt;

  assign unused_cnt = ^{tmo_cnt, settle_cnt};

  dbf_line_sequencer_tc_counter #(
    .Width (TmoWd),
    .Limit (TX_TIMEOUT - 1)
  ) u_tmo_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != StTxWait),
    .en_i  (state_q == StTxWait),
    .cnt_o (tmo_cnt),
    .tc_o  (tmo_tc)
  );

  dbf_line_sequencer_tc_counter #(
    .Width (8),
    .Limit (SettleLimit)
  ) u_settle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != StSettle),
    .en_i  (state_q == StSettle),
    .cnt_o (settle_cnt),
    .tc_o  (settle_tc)
  );

  // Tracks the sample index currently on dbf_lut_addr while in ACQ.
  dbf_line_sequencer_tc_counter #(
    .Width (ADDR_WD),
    .Limit (DEPTH - 1)
  ) u_samp_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != StAcq),
    .en_i  (state_q == StAcq),
    .cnt_o (samp_cnt),
    .tc_o  (samp_tc)
  );

  always_comb begin
    state_d    = state_q;
    seen_hi_d  = seen_hi_q;
    lut_addr_d = '0;
    lut_we_d   = 1'b0;
    ack_d      = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (line_trig_i) begin
          state_d = StTxWait;
        end else if (host_wr_req_i) begin
          state_d    = StWr;
          lut_addr_d = host_wr_addr_i;
          lut_we_d   = 1'b1;
          ack_d      = 1'b1;
        end
      end
      StWr: state_d = StIdle;
      StTxWait: begin
        if (tx_en_i) begin
          seen_hi_d = 1'b1;
        end
        // A falling edge on the final timeout cycle still starts the line.
        if (seen_hi_q && !tx_en_i) begin
          state_d = NoSettle ? StAcq : StSettle;
          start_d = NoSettle;
        end else if (tmo_tc) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StSettle: begin
        if (settle_tc) begin
          state_d = StAcq;
          start_d = 1'b1;
        end
      end
      StAcq: begin
        if (tx_en_i) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (samp_tc) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          start_d    = 1'b1;
          lut_addr_d = samp_cnt + ADDR_WD'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Overrun shares the single err pulse with timeout/abort.
    if ((state_q != StIdle) && line_trig_i) begin
      err_d = 1'b1;
    end
    if (state_d != StTxWait) begin
      seen_hi_d = 1'b0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      seen_hi_q  <= 1'b0;
      lut_addr_q <= '0;
      lut_we_q   <= 1'b0;
      ack_q      <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seen_hi_q  <= seen_hi_d;
      lut_addr_q <= lut_addr_d;
      lut_we_q   <= lut_we_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign host_wr_ack_o  = ack_q;
  assign dbf_lut_addr_o = lut_addr_q;
  assign dbf_lut_we_o   = lut_we_q;
  assign start_o        = start_q;
  assign line_busy_o    = busy_q;
  assign line_done_o    = done_q;
  assign line_err_o     = err_q;

endmodule

// File: tb/tb_dbf_line_sequencer.sv
// Bench for dbf_line_sequencer: per-scenario expected timelines are built from the line
// timing rules, then driven and compared cycle by cycle.
module tb_dbf_line_sequencer;

  localparam int unsigned AW = 10;
  localparam int D  = 8;
  localparam int S  = 2;
  localparam int TO = 16;
  localparam int ML = 64;

  logic          clk = 1'b0;
  logic          rst, line_trig, tx_en, host_wr_req;
  logic [AW-1:0] host_wr_addr;
  logic          host_wr_ack, dbf_lut_we, start, line_busy, line_done, line_err;
  logic [AW-1:0] dbf_lut_addr;

  always #5 clk = ~clk;

  dbf_line_sequencer #(
    .ADDR_WD    (AW),
    .DEPTH      (D),
    .SETTLE     (S),
    .TX_TIMEOUT (TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .line_trig_i    (line_trig),
    .tx_en_i        (tx_en),
    .host_wr_req_i  (host_wr_req),
    .host_wr_addr_i (host_wr_addr),
    .host_wr_ack_o  (host_wr_ack),
    .dbf_lut_addr_o (dbf_lut_addr),
    .dbf_lut_we_o   (dbf_lut_we),
    .start_o        (start),
    .line_busy_o    (line_busy),
    .line_done_o    (line_done),
    .line_err_o     (line_err)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus (index n = value sampled at edge n) and expected outputs after edge n.
  logic          s_rst [ML], s_trig [ML], s_tx [ML], s_req [ML];
  logic [AW-1:0] s_addr [ML], e_addr [ML];
  logic          e_we [ML], e_ack [ML], e_start [ML], e_busy [ML], e_done [ML], e_err [ML];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tl();
    for (int i = 0; i < ML; i++) begin
      s_rst[i] = 0; s_trig[i] = 0; s_tx[i] = 0; s_req[i] = 0; s_addr[i] = '0;
      e_addr[i] = '0; e_we[i] = 0; e_ack[i] = 0; e_start[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
    end
  endtask

  // Host request held from input 'from' until it is served at 'at'.
  task automatic add_write(input int from, input int at, input logic [AW-1:0] a);
    for (int i = from; i <= at; i++) begin
      s_req[i]  = 1'b1;
      s_addr[i] = a;
    end
    e_we[at] = 1'b1; e_ack[at] = 1'b1; e_busy[at] = 1'b1; e_addr[at] = a;
  endtask

  // Line triggered at input b: tx_en low 'lead' cycles, high 'high' cycles. abort_k>=0 raises
  // tx_en during sample abort_k; ovr_j>=0 retriggers (during ACQ sample ovr_j, or during
  // TX_WAIT cycle ovr_j on a timeout). Returns the first idle index and the ACQ start index.
  task automatic add_line(input int b, input int lead, input int high, input int abort_k,
                          input int ovr_j, output int e, output int acq);
    int f;
    f = lead + high + 1;
    s_trig[b] = 1'b1;
    for (int i = 1; i <= high; i++) s_tx[b + lead + i] = 1'b1;
    acq = -1;
    if (high == 0 || f > TO) begin
      for (int n = 0; n < TO; n++) e_busy[b + n] = 1'b1;
      e_err[b + TO] = 1'b1;
      if (ovr_j >= 0) begin
        s_trig[b + 1 + ovr_j] = 1'b1;
        e_err[b + 1 + ovr_j]  = 1'b1;
      end
      e = (b + TO + 1 > b + lead + high + 1) ? b + TO + 1 : b + lead + high + 1;
    end else begin
      acq = b + f + S;
      for (int n = 0; n < f + S; n++) e_busy[b + n] = 1'b1;
      for (int k = 0; k < D; k++) begin
        if (abort_k < 0 || k <= abort_k) begin
          e_start[acq + k] = 1'b1;
          e_addr[acq + k]  = AW'(k);
          e_busy[acq + k]  = 1'b1;
        end
      end
      if (abort_k >= 0) begin
        s_tx[acq + abort_k + 1]  = 1'b1;
        e_err[acq + abort_k + 1] = 1'b1;
        e = acq + abort_k + 2;
      end else begin
        e_done[acq + D] = 1'b1;
        e_busy[acq + D] = 1'b1;
        e = acq + D + 1;
      end
      if (ovr_j >= 0 && (abort_k < 0 || ovr_j <= abort_k)) begin
        s_trig[acq + ovr_j + 1] = 1'b1;
        e_err[acq + ovr_j + 1]  = 1'b1;
      end
    end
  endtask

  // Reset sampled at edge r clears everything from that cycle on.
  task automatic add_reset(input int r);
    s_rst[r] = 1'b1;
    for (int i = r; i < ML; i++) begin
      s_trig[i] = 0; s_tx[i] = 0; s_req[i] = 0;
      e_addr[i] = '0; e_we[i] = 0; e_ack[i] = 0; e_start[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
    end
  endtask

  task automatic run_tl(input string name, input int len);
    for (int n = 0; n < len; n++) begin
      rst = s_rst[n]; line_trig = s_trig[n]; tx_en = s_tx[n];
      host_wr_req = s_req[n]; host_wr_addr = s_addr[n];
      @(negedge clk);
      check_eq($sformatf("%s c%0d addr", name, n), 32'(dbf_lut_addr), 32'(e_addr[n]));
      check_eq($sformatf("%s c%0d we", name, n), 32'(dbf_lut_we), 32'(e_we[n]));
      check_eq($sformatf("%s c%0d ack", name, n), 32'(host_wr_ack), 32'(e_ack[n]));
      check_eq($sformatf("%s c%0d start", name, n), 32'(start), 32'(e_start[n]));
      check_eq($sformatf("%s c%0d busy", name, n), 32'(line_busy), 32'(e_busy[n]));
      check_eq($sformatf("%s c%0d done", name, n), 32'(line_done), 32'(e_done[n]));
      check_eq($sformatf("%s c%0d err", name, n), 32'(line_err), 32'(e_err[n]));
    end
    rst = 0; line_trig = 0; tx_en = 0; host_wr_req = 0; host_wr_addr = '0;
  endtask

  initial begin
    int e, e2, acq, lead, high, b, kind, ab, ov;
    rst = 1; line_trig = 0; tx_en = 0; host_wr_req = 0; host_wr_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst addr", 32'(dbf_lut_addr), 32'h0);
    check_eq("rst we", 32'(dbf_lut_we), 32'h0);
    check_eq("rst ack", 32'(host_wr_ack), 32'h0);
    check_eq("rst start", 32'(start), 32'h0);
    check_eq("rst busy", 32'(line_busy), 32'h0);
    check_eq("rst done", 32'(line_done), 32'h0);
    check_eq("rst err", 32'(line_err), 32'h0);
    rst = 0;
    @(negedge clk);

    clear_tl(); add_write(0, 0, AW'('h155)); run_tl("write", 3);
    clear_tl(); add_line(0, 0, 5, -1, -1, e, acq); run_tl("normal", e + 1);
    clear_tl(); add_line(0, 0, 0, -1, -1, e, acq); run_tl("timeout", e + 1);
    clear_tl(); add_line(0, 1, 4, 3, -1, e, acq); run_tl("abort", e + 1);
    clear_tl(); add_line(0, 0, 5, -1, 4, e, acq);
    add_write(0, e + 1, AW'('h2a7)); run_tl("trigreq", e + 3);
    clear_tl(); add_line(0, 0, 3, -1, -1, e, acq); add_reset(acq + 6);
    add_line(acq + 7, 0, 2, -1, -1, e2, acq); run_tl("reset", e2 + 1);

    for (int it = 0; it < 30; it++) begin
      clear_tl();
      kind = int'($urandom_range(0, 4));
      lead = int'($urandom_range(0, 5));
      ab = -1; ov = -1;
      case (kind)
        0: begin
          b = 0;
          for (int w = 0; w < 4; w++) begin
            add_write(b, b, AW'($urandom));
            b += 2 + int'($urandom_range(0, 2));
          end
          e = b;
        end
        1: begin
          high = int'($urandom_range(1, 15 - lead));
          add_line(0, lead, high, -1, -1, e, acq);
        end
        2: begin
          high = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(16 - lead, 20 - lead));
          if ($urandom_range(0, 1) == 1) ov = int'($urandom_range(0, TO - 1));
          add_line(0, lead, high, -1, ov, e, acq);
        end
        3: begin
          high = int'($urandom_range(1, 15 - lead));
          ab = int'($urandom_range(0, D - 1));
          if ($urandom_range(0, 1) == 1) ov = int'($urandom_range(0, ab));
          add_line(0, lead, high, ab, ov, e, acq);
        end
        default: begin
          high = int'($urandom_range(1, 15 - lead));
          ov = int'($urandom_range(0, D - 1));
          add_line(0, lead, high, -1, ov, e, acq);
          if ($urandom_range(0, 1) == 1) begin
            add_write(0, e + 1, AW'($urandom));
            e = e + 2;
          end
        end
      endcase
      run_tl($sformatf("rnd%0d", it), e + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
